plab4_net_router_input_ctrl_arb_multi: RTL and testbench



---
 rtl/plab4_net_arb_pkg.sv | 12 +
 rtl/plab4_net_RouterInputCtrl.sv | 29 ++
 rtl/plab4_net_rr_prio_pick.sv | 28 ++
 rtl/plab4_net_router_input_ctrl_arb_multi.sv | 132 +++++++++++++
 tb/tb_plab4_net_router_input_ctrl_arb_multi.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/plab4_net_arb_pkg.sv
// rtl/plab4_net_arb_pkg.sv - shared constants and helpers for the input-port domain arbiter
package plab4_net_arb_pkg;

  localparam int ARB_MODE_RR  = 0;
  localparam int ARB_MODE_TDM = 1;

  // (value + 1) mod n, valid for 0 <= value < n
  function automatic int mod_incr(input int value, input int n);
    return (value + 1 >= n) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/plab4_net_RouterInputCtrl.sv
// rtl/plab4_net_RouterInputCtrl.sv - per-buffer route unit: destination to output-port requests
module plab4_net_RouterInputCtrl #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_num_ports   = 3,
  parameter logic [p_num_ports-1:0] p_default_reqs = 3'b001,
  localparam int c_dest_nbits = $clog2(p_num_routers)
) (
  input  logic [c_dest_nbits-1:0] dest,
  input  logic                    in_val,
  output logic                    in_rdy,
  output logic [p_num_ports-1:0]  reqs,
  input  logic [p_num_ports-1:0]  grants
);

  localparam logic [c_dest_nbits-1:0] c_id        = c_dest_nbits'(p_router_id);
  // port 1 is the local terminal port
  localparam logic [p_num_ports-1:0]  c_term_reqs = p_num_ports'(2);

  // Local messages go to the terminal, everything else passes through
  always_comb begin
    reqs = '0;
    if (in_val) begin
      reqs = (dest == c_id) ? c_term_reqs : p_default_reqs;
    end
    in_rdy = |(reqs & grants);
  end

endmodule

// File: rtl/plab4_net_rr_prio_pick.sv
// rtl/plab4_net_rr_prio_pick.sv - N-way cyclic priority pick starting at a pointer
module plab4_net_rr_prio_pick #(
  parameter int p_n = 2,
  localparam int c_idx_nbits = (p_n > 1) ? $clog2(p_n) : 1
) (
  input  logic [p_n-1:0]         reqs,
  input  logic [c_idx_nbits-1:0] ptr,
  output logic [c_idx_nbits-1:0] winner,
  output logic                   val
);

  // Scan ptr, ptr+1, ... (mod p_n) and take the first requester
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    val    = 1'b0;
    for (int i = 0; i < p_n; i++) begin
      idx = int'(ptr) + i;
      if (idx >= p_n) idx = idx - p_n;
      if (!val && reqs[idx]) begin
        winner = c_idx_nbits'(idx);
        val    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plab4_net_router_input_ctrl_arb_multi.sv
// rtl/plab4_net_router_input_ctrl_arb_multi.sv - per-input-port arbiter merging per-domain route requests
module plab4_net_router_input_ctrl_arb_multi
  import plab4_net_arb_pkg::*;
#(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_num_domains = 2,
  parameter int p_num_ports   = 3,
  parameter logic [p_num_ports-1:0] p_default_reqs = 3'b001,
  parameter int p_mode        = ARB_MODE_RR,
  parameter int p_slot_len    = 4,
  localparam int c_dest_nbits = $clog2(p_num_routers),
  localparam int c_dom_nbits  = (p_num_domains > 1) ? $clog2(p_num_domains) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [p_num_domains*c_dest_nbits-1:0] dest,
  input  logic [p_num_domains-1:0]              in_val,
  output logic [p_num_domains-1:0]              in_rdy,
  output logic [p_num_ports-1:0]                reqs,
  input  logic [p_num_ports-1:0]                grants,
  output logic [c_dom_nbits-1:0]                domain,
  output logic                                  domain_val
);

  localparam int c_slot_nbits = (p_slot_len > 1) ? $clog2(p_slot_len) : 1;
  localparam logic [c_slot_nbits-1:0] c_slot_last = c_slot_nbits'(p_slot_len - 1);

  logic [p_num_domains-1:0][p_num_ports-1:0] reqs_d;
  logic [p_num_domains-1:0][p_num_ports-1:0] grants_d;
  logic [p_num_domains-1:0]                  req_any;

  logic [c_dom_nbits-1:0]  rr_ptr;
  logic [c_dom_nbits-1:0]  lock_dom;
  logic                    lock_val;
  logic [c_slot_nbits-1:0] slot_cnt;
  logic [c_dom_nbits-1:0]  slot_own;

  logic [c_dom_nbits-1:0]  pick_dom;
  logic                    pick_val;
  logic [c_dom_nbits-1:0]  winner;
  logic                    win_val;
  logic                    xfer;

  genvar d;
  generate
    for (d = 0; d < p_num_domains; d++) begin : g_dom
      plab4_net_RouterInputCtrl #(
        .p_router_id    (p_router_id),
        .p_num_routers  (p_num_routers),
        .p_num_ports    (p_num_ports),
        .p_default_reqs (p_default_reqs)
      ) route_unit (
        .dest   (dest[d*c_dest_nbits +: c_dest_nbits]),
        .in_val (in_val[d]),
        .in_rdy (in_rdy[d]),
        .reqs   (reqs_d[d]),
        .grants (grants_d[d])
      );

      assign req_any[d] = |reqs_d[d];
      // Only the winning domain ever sees the output-port grants
      assign grants_d[d] = (domain_val && (winner == c_dom_nbits'(d))) ? grants : '0;
    end
  endgenerate

  plab4_net_rr_prio_pick #(
    .p_n (p_num_domains)
  ) rr_pick (
    .reqs   (req_any),
    .ptr    (rr_ptr),
    .winner (pick_dom),
    .val    (pick_val)
  );

  // Winner selection: TDM slot owner, else sticky lock, else round-robin pick
  always_comb begin
    winner  = '0;
    win_val = 1'b0;
    if (p_mode == ARB_MODE_TDM) begin
      winner  = slot_own;
      win_val = req_any[slot_own];
    end else if (lock_val && req_any[lock_dom]) begin
      winner  = lock_dom;
      win_val = 1'b1;
    end else begin
      winner  = pick_dom;
      win_val = pick_val;
    end
  end

  // Gating with reset makes every output drop the moment reset asserts
  assign domain_val = reset & win_val;
  assign domain     = reset ? winner : '0;
  assign reqs       = domain_val ? reqs_d[winner] : '0;
  assign xfer       = domain_val & in_val[winner] & in_rdy[winner];

  // Round-robin pointer and sticky lock: a blocked winner keeps the port until it transfers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      lock_val <= 1'b0;
      lock_dom <= '0;
    end else if (p_mode == ARB_MODE_RR) begin
      if (xfer) begin
        rr_ptr   <= c_dom_nbits'(mod_incr(32'(winner), p_num_domains));
        lock_val <= 1'b0;
      end else if (domain_val) begin
        lock_val <= 1'b1;
        lock_dom <= winner;
      end else begin
        lock_val <= 1'b0;
      end
    end
  end

  // TDM slot timer: advances every cycle regardless of traffic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      slot_own <= '0;
    end else if (p_mode == ARB_MODE_TDM) begin
      if (slot_cnt == c_slot_last) begin
        slot_cnt <= '0;
        slot_own <= c_dom_nbits'(mod_incr(32'(slot_own), p_num_domains));
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_arb_multi.sv
// tb/tb_plab4_net_router_input_ctrl_arb_multi.sv - directed self-checking bench for the domain arbiter
module tb_plab4_net_router_input_ctrl_arb_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // instance a: RR, two domains
  logic [5:0] dest_a;
  logic [1:0] in_val_a, in_rdy_a;
  logic [2:0] reqs_a, grants_a;
  logic [0:0] domain_a;
  logic       domain_val_a;

  // instance b: RR, three domains
  logic [8:0] dest_b;
  logic [2:0] in_val_b, in_rdy_b;
  logic [2:0] reqs_b, grants_b;
  logic [1:0] domain_b;
  logic       domain_val_b;

  // instance c: TDM, three domains, 4-cycle slots
  logic [8:0] dest_c;
  logic [2:0] in_val_c, in_rdy_c;
  logic [2:0] reqs_c, grants_c;
  logic [1:0] domain_c;
  logic       domain_val_c;

  int passed = 0;
  int total  = 0;

  plab4_net_router_input_ctrl_arb_multi #(
    .p_num_domains (2), .p_mode (0)
  ) dut_a (
    .clk (clk), .reset (reset), .dest (dest_a), .in_val (in_val_a), .in_rdy (in_rdy_a),
    .reqs (reqs_a), .grants (grants_a), .domain (domain_a), .domain_val (domain_val_a)
  );

  plab4_net_router_input_ctrl_arb_multi #(
    .p_num_domains (3), .p_mode (0)
  ) dut_b (
    .clk (clk), .reset (reset), .dest (dest_b), .in_val (in_val_b), .in_rdy (in_rdy_b),
    .reqs (reqs_b), .grants (grants_b), .domain (domain_b), .domain_val (domain_val_b)
  );

  plab4_net_router_input_ctrl_arb_multi #(
    .p_num_domains (3), .p_mode (1), .p_slot_len (4)
  ) dut_c (
    .clk (clk), .reset (reset), .dest (dest_c), .in_val (in_val_c), .in_rdy (in_rdy_c),
    .reqs (reqs_c), .grants (grants_c), .domain (domain_c), .domain_val (domain_val_c)
  );

  // lock scenario vectors: in_val, grants, expected domain, expected in_rdy
  logic [2:0] lk_val  [7] = '{3'b110, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b110};
  logic [2:0] lk_gnt  [7] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000};
  logic [1:0] lk_dom  [7] = '{2'd1,   2'd1,   2'd1,   2'd1,   2'd2,   2'd0,   2'd1};
  logic [2:0] lk_rdy  [7] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000, 3'b000};

  // wrap scenario vectors
  logic [2:0] wr_val  [5] = '{3'b100, 3'b111, 3'b111, 3'b111, 3'b111};
  logic [1:0] wr_dom  [5] = '{2'd2,   2'd0,   2'd1,   2'd2,   2'd0};
  logic [2:0] wr_rdy  [5] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

  task automatic do_reset;
    @(negedge clk);
    reset    = 1'b0;
    in_val_a = '0; in_val_b = '0; in_val_c = '0;
    grants_a = '0; grants_b = '0; grants_c = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    dest_a   = {3'd3, 3'd3};
    dest_b   = {3'd3, 3'd3, 3'd3};
    dest_c   = {3'd3, 3'd3, 3'd3};
    in_val_a = '1; in_val_b = '1; in_val_c = '1;
    grants_a = '1; grants_b = '1; grants_c = '1;
    #2;
    total++; if (in_rdy_a !== 2'b00) $display("FAIL reset_in_rdy_a got %b want 00", in_rdy_a); else passed++;
    total++; if (reqs_a !== 3'b000) $display("FAIL reset_reqs_a got %b want 000", reqs_a); else passed++;
    total++; if (domain_val_a !== 1'b0) $display("FAIL reset_dval_a got %b want 0", domain_val_a); else passed++;
    total++; if (domain_a !== 1'b0) $display("FAIL reset_domain_a got %0d want 0", domain_a); else passed++;
    total++; if (in_rdy_b !== 3'b000) $display("FAIL reset_in_rdy_b got %b want 000", in_rdy_b); else passed++;
    total++; if (domain_val_b !== 1'b0) $display("FAIL reset_dval_b got %b want 0", domain_val_b); else passed++;
    total++; if (in_rdy_c !== 3'b000) $display("FAIL reset_in_rdy_c got %b want 000", in_rdy_c); else passed++;
    total++; if (reqs_c !== 3'b000) $display("FAIL reset_reqs_c got %b want 000", reqs_c); else passed++;
  endtask

  task automatic test_rr_alternate;
    logic [0:0] exp_dom;
    logic [1:0] exp_rdy;
    logic [2:0] exp_reqs;
    do_reset;
    dest_a   = {3'd0, 3'd3};  // domain 1 is local (terminal), domain 0 passes through
    in_val_a = 2'b11;
    grants_a = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_dom  = (k % 2 == 0) ? 1'b0 : 1'b1;
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_reqs = (k % 2 == 0) ? 3'b001 : 3'b010;
      total++; if (domain_a !== exp_dom) $display("FAIL rr_alt_domain k=%0d got %0d want %0d", k, domain_a, exp_dom); else passed++;
      total++; if (in_rdy_a !== exp_rdy) $display("FAIL rr_alt_in_rdy k=%0d got %b want %b", k, in_rdy_a, exp_rdy); else passed++;
      total++; if (reqs_a !== exp_reqs) $display("FAIL rr_alt_reqs k=%0d got %b want %b", k, reqs_a, exp_reqs); else passed++;
      total++; if (domain_val_a !== 1'b1) $display("FAIL rr_alt_dval k=%0d got %b want 1", k, domain_val_a); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_rr_lock;
    do_reset;
    dest_b = {3'd3, 3'd3, 3'd3};
    for (int k = 0; k < 7; k++) begin
      in_val_b = lk_val[k];
      grants_b = lk_gnt[k];
      #1;
      total++; if (domain_b !== lk_dom[k]) $display("FAIL rr_lock_domain k=%0d got %0d want %0d", k, domain_b, lk_dom[k]); else passed++;
      total++; if (in_rdy_b !== lk_rdy[k]) $display("FAIL rr_lock_in_rdy k=%0d got %b want %b", k, in_rdy_b, lk_rdy[k]); else passed++;
      total++; if (domain_val_b !== 1'b1) $display("FAIL rr_lock_dval k=%0d got %b want 1", k, domain_val_b); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_rr_wrap;
    do_reset;
    dest_b   = {3'd3, 3'd3, 3'd3};
    grants_b = 3'b111;
    for (int k = 0; k < 5; k++) begin
      in_val_b = wr_val[k];
      #1;
      total++; if (domain_b !== wr_dom[k]) $display("FAIL rr_wrap_domain k=%0d got %0d want %0d", k, domain_b, wr_dom[k]); else passed++;
      total++; if (in_rdy_b !== wr_rdy[k]) $display("FAIL rr_wrap_in_rdy k=%0d got %b want %b", k, in_rdy_b, wr_rdy[k]); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_tdm;
    logic [1:0] owner;
    logic       exp_v;
    do_reset;
    dest_c   = {3'd3, 3'd3, 3'd3};
    in_val_c = 3'b010;
    grants_c = 3'b111;
    for (int k = 0; k < 24; k++) begin
      #1;
      owner = 2'((k / 4) % 3);
      exp_v = (owner == 2'd1);
      total++; if (in_rdy_c !== {1'b0, exp_v, 1'b0}) $display("FAIL tdm_in_rdy k=%0d got %b want %b", k, in_rdy_c, {1'b0, exp_v, 1'b0}); else passed++;
      total++; if (domain_val_c !== exp_v) $display("FAIL tdm_dval k=%0d got %b want %b", k, domain_val_c, exp_v); else passed++;
      total++; if (domain_c !== owner) $display("FAIL tdm_domain k=%0d got %0d want %0d", k, domain_c, owner); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_tdm_isolation;
    logic [1:0] owner;
    logic       tog;
    logic [2:0] exp_rdy;
    do_reset;
    dest_c   = {3'd3, 3'd3, 3'd0};
    grants_c = 3'b111;
    for (int k = 0; k < 24; k++) begin
      tog      = ((k / 3) % 2) == 0;
      in_val_c = {1'b0, 1'b1, tog};
      #1;
      owner   = 2'((k / 4) % 3);
      exp_rdy = {1'b0, owner == 2'd1, (owner == 2'd0) && tog};
      total++; if (in_rdy_c !== exp_rdy) $display("FAIL tdm_iso_in_rdy k=%0d got %b want %b", k, in_rdy_c, exp_rdy); else passed++;
      if (owner == 2'd0 && tog) begin
        total++; if (reqs_c !== 3'b010) $display("FAIL tdm_iso_reqs k=%0d got %b want 010", k, reqs_c); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    dest_a   = {3'd3, 3'd3};
    in_val_a = 2'b11;
    grants_a = 3'b111;
    #1;
    total++; if (in_rdy_a !== 2'b01) $display("FAIL rmid_pre0 got %b want 01", in_rdy_a); else passed++;
    @(negedge clk);
    #1;
    total++; if (in_rdy_a !== 2'b10) $display("FAIL rmid_pre1 got %b want 10", in_rdy_a); else passed++;
    #1;
    reset = 1'b0;
    #1;
    total++; if (in_rdy_a !== 2'b00) $display("FAIL rmid_in_rdy got %b want 00", in_rdy_a); else passed++;
    total++; if (reqs_a !== 3'b000) $display("FAIL rmid_reqs got %b want 000", reqs_a); else passed++;
    total++; if (domain_val_a !== 1'b0) $display("FAIL rmid_dval got %b want 0", domain_val_a); else passed++;
    @(negedge clk);
    reset    = 1'b1;
    in_val_a = 2'b00;
    in_val_c = 3'b001;
    grants_c = 3'b111;
    dest_c   = {3'd3, 3'd3, 3'd3};
    #1;
    total++; if (in_rdy_a !== 2'b00) $display("FAIL rmid_no_pulse got %b want 00", in_rdy_a); else passed++;
    total++; if (domain_val_c !== 1'b1 || domain_c !== 2'd0) $display("FAIL rmid_tdm_owner got val=%b dom=%0d want val=1 dom=0", domain_val_c, domain_c); else passed++;
    @(negedge clk);
    in_val_a = 2'b11;
    #1;
    total++; if (domain_a !== 1'b0) $display("FAIL rmid_rr_ptr got %0d want 0", domain_a); else passed++;
    total++; if (in_rdy_a !== 2'b01) $display("FAIL rmid_re_present got %b want 01", in_rdy_a); else passed++;
  endtask

  initial begin
    test_reset;
    test_rr_alternate;
    test_rr_lock;
    test_rr_wrap;
    test_tdm;
    test_tdm_isolation;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
